cache_ctrl: RTL and testbench
=============================

// Module: cache_ctrl
// PURPOSE
//  Miss/write sequencer for the direct-mapped data cache in the memory stage.
//  Serves hits in zero cycles; on a miss or store, stalls the pipeline and runs a
//  req/ready transaction to multi-cycle main memory. Drives cache refill, update and
//  invalidate strobes; keeps hit/miss counters. Write-through, no write-allocate.
// PARAMETERS
//  CNT_WIDTH  32  width of hit_count / miss_count (saturating)
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst          in   1   synchronous, active-high reset
//  cpu_re       in   1   load request from memory stage
//  cpu_we       in   1   store request from memory stage
//  cpu_addr     in   32  byte address
//  cpu_width    in   3   000 LW, 001 LH, 010 LB, 101 LHU, 110 LBU (stores: 000/001/010)
//  cpu_wdata    in   32  store data, right-aligned
//  cache_hit    in   1   lookup result for cpu_addr (tag match & valid)
//  cache_rdata  in   32  word stored in the indexed line
//  cpu_rdata    out  32  extended load result
//  stall        out  1   freeze pipeline
//  mem_req      out  1   memory request, held until mem_ready
//  mem_we       out  1   1 = write transaction
//  mem_addr     out  32  request address (registered)
//  mem_wdata    out  32  write data (registered)
//  mem_width    out  3   access width sent to memory
//  mem_rdata    in   32  read data, valid with mem_ready
//  mem_ready    in   1   one-cycle completion pulse
//  fill_en      out  1   1-cycle pulse: write fill_data into line of cpu_addr, set valid
//  fill_data    out  32  refill word
//  upd_en       out  1   1-cycle pulse: cache merges cpu_wdata per cpu_width
//  inv_en       out  1   1-cycle pulse: invalidate indexed line (unaligned store)
//  hit_count    out  CNT_WIDTH  served-from-cache loads
//  miss_count   out  CNT_WIDTH  loads sent to memory
// BEHAVIOUR
//  aligned = cpu_addr[1:0]==0. Reset: state IDLE, all outputs 0, counters 0.
//  IDLE: cpu_we has priority over cpu_re.
//   load, aligned & cache_hit: cpu_rdata = ext(cache_rdata), stall=0, hit_count++.
//   load, miss or unaligned: stall=1 combinationally that cycle; next state RD;
//    latch addr/width; mem_width=000 if aligned (word refill), else cpu_width.
//   store: stall=1; next state WR; latch addr/wdata/width; mem_width=cpu_width.
//  RD: mem_req=1, mem_we=0, stall=1. On mem_ready: capture mem_rdata into rbuf,
//   miss_count++, fill_en=1 that cycle iff aligned -> DONE.
//  WR: mem_req=1, mem_we=1, stall=1. On mem_ready: upd_en=1 if aligned else inv_en=1
//   -> DONE.
//  DONE: stall=0 for exactly one cycle; for loads cpu_rdata = ext(rbuf)
//   (aligned: extract from word; unaligned: memory already returned width data).
//   Returns to IDLE; next request is not accepted until the following cycle.
//  ext: LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend, LW/other pass through.
//  mem_req never drops before mem_ready; mem_ready outside RD/WR is ignored.
//  mem_ready in the same cycle as the RD/WR entry edge is accepted (1-cycle memory).
//  Counters saturate at all-ones; never wrap.
//  rst mid-transaction: back to IDLE, mem_req drops same edge, no fill/upd/inv pulse.
//  At most one of fill_en/upd_en/inv_en high in any cycle.
// STRUCTURE
//  cache_pkg: width_t enum (LW, LH, LB, LHU, LBU encodings), state_t {IDLE, RD, WR, DONE}.
//  Sub-module load_ext (combinational width extract/extend), used for both
//  cache_rdata and rbuf paths. FSM, latches and counters live in cache_ctrl.
// TESTING
//  LW 0x100, cache_hit=1, cache_rdata=0xDEADBEEF -> cpu_rdata 0xDEADBEEF, stall 0,
//   hit_count 1.
//  LB 0x104 miss, mem_ready 3 cycles later with 0x00000080 -> fill_en once,
//   cpu_rdata 0xFFFFFF80 in DONE, miss_count 1.
//  SW 0x108 data 0x12345678 -> mem_req+mem_we held until ready, upd_en 1 pulse,
//   stall drops in DONE.
//  SH 0x10A (unaligned) -> mem_width 001, inv_en pulse, no upd_en.
//  rst asserted during RD -> IDLE next edge, mem_req 0, no fill_en, counters 0.
//  Force hit_count to all-ones, hit again -> stays all-ones.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the memory-stage data cache controller.
package cache_pkg;

  typedef enum logic [2:0] {
    W_LW  = 3'b000,
    W_LH  = 3'b001,
    W_LB  = 3'b010,
    W_LHU = 3'b101,
    W_LBU = 3'b110
  } width_t;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

endpackage

// File: rtl/cache_ctrl_load_ext.sv
// Right-aligned load extraction: sign/zero extension of the low byte or halfword.
module load_ext
  import cache_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  width,
  output logic [31:0] result
);

  width_t w;

  assign w = width_t'(width);

  always_comb begin
    result = data;
    case (w)
      W_LB:    result = {{24{data[7]}}, data[7:0]};
      W_LBU:   result = {24'h000000, data[7:0]};
      W_LH:    result = {{16{data[15]}}, data[15:0]};
      W_LHU:   result = {16'h0000, data[15:0]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/cache_ctrl.sv
// Miss/store sequencer for the direct-mapped write-through data cache:
// zero-cycle hits, stalled req/ready memory transactions, refill/update/invalidate strobes.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_re,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_addr,
  input  logic [2:0]           cpu_width,
  input  logic [31:0]          cpu_wdata,
  input  logic                 cache_hit,
  input  logic [31:0]          cache_rdata,
  output logic [31:0]          cpu_rdata,
  output logic                 stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [2:0]           mem_width,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready,
  output logic                 fill_en,
  output logic [31:0]          fill_data,
  output logic                 upd_en,
  output logic                 inv_en,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  state_t      state;
  logic [2:0]  ld_width;
  logic        op_load;
  logic [31:0] rbuf;

  logic        aligned;
  logic        req_aligned;
  logic        load_req;
  logic        load_hit;
  logic        go_mem;
  logic        in_xfer;
  logic        xfer_done;
  logic [31:0] hit_data;
  logic [31:0] buf_data;

  assign aligned     = (cpu_addr[1:0] == 2'b00);
  assign req_aligned = (mem_addr[1:0] == 2'b00);
  assign load_req    = cpu_re && !cpu_we;
  assign load_hit    = (state == IDLE) && load_req && aligned && cache_hit;
  assign go_mem      = (state == IDLE) && (cpu_we || (cpu_re && !(aligned && cache_hit)));
  assign in_xfer     = (state == RD) || (state == WR);
  // rst gates every combinational strobe so an abandoned transaction leaves no trace.
  assign xfer_done   = !rst && in_xfer && mem_ready;

  load_ext u_hit_ext (
    .data   (cache_rdata),
    .width  (cpu_width),
    .result (hit_data)
  );

  load_ext u_buf_ext (
    .data   (rbuf),
    .width  (ld_width),
    .result (buf_data)
  );

  always_comb begin
    cpu_rdata = '0;
    if (!rst) begin
      if (load_hit)
        cpu_rdata = hit_data;
      else if (state == DONE && op_load)
        cpu_rdata = buf_data;
    end
  end

  assign stall     = !rst && (go_mem || in_xfer);
  assign mem_req   = in_xfer;
  assign mem_we    = (state == WR);
  assign fill_en   = xfer_done && (state == RD) && req_aligned;
  assign fill_data = fill_en ? mem_rdata : '0;
  assign upd_en    = xfer_done && (state == WR) && req_aligned;
  assign inv_en    = xfer_done && (state == WR) && !req_aligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ld_width   <= '0;
      op_load    <= 1'b0;
      rbuf       <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_width  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_we) begin
            state     <= WR;
            op_load   <= 1'b0;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_width <= cpu_width;
          end else if (cpu_re) begin
            if (aligned && cache_hit) begin
              if (hit_count != '1)
                hit_count <= hit_count + CNT_WIDTH'(1);
            end else begin
              state     <= RD;
              op_load   <= 1'b1;
              ld_width  <= cpu_width;
              mem_addr  <= cpu_addr;
              // Aligned misses refill the whole word; unaligned ones fetch just the datum.
              mem_width <= aligned ? 3'b000 : cpu_width;
            end
          end
        end
        RD: begin
          if (mem_ready) begin
            rbuf  <= mem_rdata;
            state <= DONE;
            if (miss_count != '1)
              miss_count <= miss_count + CNT_WIDTH'(1);
          end
        end
        WR: begin
          if (mem_ready)
            state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized scoreboard bench for cache_ctrl with a small-width counter instance.
module tb_cache_ctrl;

  localparam int CW     = 4;
  localparam int SATMAX = 15;

  logic          clk, rst;
  logic          cpu_re, cpu_we, cache_hit;
  logic [31:0]   cpu_addr, cpu_wdata, cache_rdata;
  logic [2:0]    cpu_width;
  logic [31:0]   cpu_rdata;
  logic          stall, mem_req, mem_we, mem_ready;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata, fill_data;
  logic [2:0]    mem_width;
  logic          fill_en, upd_en, inv_en;
  logic [CW-1:0] hit_count, miss_count;

  cache_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_width(cpu_width), .cpu_wdata(cpu_wdata), .cache_hit(cache_hit),
    .cache_rdata(cache_rdata), .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_width(mem_width), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .fill_en(fill_en), .fill_data(fill_data), .upd_en(upd_en), .inv_en(inv_en),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_load;
    logic [31:0] rdata;
    int          hc, mc, fills, upds, invs, lat;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0, failures = 0;
  int          model_hc = 0, model_mc = 0;
  int          cur_lat = 0;
  logic [31:0] cur_mdata = '0, exp_maddr = '0, exp_mwdata = '0;
  logic        exp_mwe = 1'b0;
  logic [2:0]  exp_mwidth = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SATMAX) ? SATMAX : v;
  endfunction

  // Reference load result: value of the low byte/half interpreted as signed or unsigned.
  function automatic logic [31:0] ref_ext(input logic [31:0] v, input logic [2:0] w);
    int unsigned b, h;
    b = v % 256;
    h = v % 65536;
    case (w)
      3'b010:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b110:  return b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return v;
    endcase
  endfunction

  // Memory responder: answers after cur_lat waiting cycles, plus stray ready pulses when idle.
  initial begin
    int wc;
    wc = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        if (wc >= cur_lat) begin
          chk("mem_addr", mem_addr, exp_maddr);
          chk("mem_we", 32'(mem_we), 32'(exp_mwe));
          chk("mem_width", 32'(mem_width), 32'(exp_mwidth));
          if (exp_mwe) chk("mem_wdata", mem_wdata, exp_mwdata);
          mem_rdata = cur_mdata;
          mem_ready = 1'b1;
          @(posedge clk); #1;
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          wc = 0;
        end else begin
          wc++;
        end
      end else begin
        wc = 0;
        if ($urandom_range(0, 7) == 0) begin
          mem_rdata = $urandom;
          mem_ready = 1'b1;
          @(posedge clk); #1;
          mem_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: pops one expectation per completed request (request active and not stalled).
  initial begin
    int   fcnt, ucnt, icnt, cyc;
    exp_t e;
    fcnt = 0; ucnt = 0; icnt = 0; cyc = 0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        fcnt = 0; ucnt = 0; icnt = 0; cyc = 0;
      end else begin
        if (fill_en || upd_en || inv_en)
          chk("one_strobe", 32'(int'(fill_en) + int'(upd_en) + int'(inv_en)), 32'd1);
        if (fill_en) chk("fill_data", fill_data, cur_mdata);
        fcnt += int'(fill_en);
        ucnt += int'(upd_en);
        icnt += int'(inv_en);
        if (cpu_re || cpu_we) begin
          if (stall) begin
            cyc++;
          end else if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow actual=completion required=none");
          end else begin
            e = sbq.pop_front();
            if (e.is_load) chk("cpu_rdata", cpu_rdata, e.rdata);
            chk("hit_count", 32'(hit_count), 32'(e.hc));
            chk("miss_count", 32'(miss_count), 32'(e.mc));
            chk("fill_pulses", 32'(fcnt), 32'(e.fills));
            chk("upd_pulses", 32'(ucnt), 32'(e.upds));
            chk("inv_pulses", 32'(icnt), 32'(e.invs));
            chk("latency", 32'(cyc), 32'(e.lat));
            fcnt = 0; ucnt = 0; icnt = 0; cyc = 0;
          end
        end
      end
    end
  end

  task automatic do_req(input bit st, input logic [31:0] addr, input logic [2:0] w,
                        input logic [31:0] wd, input bit hit, input logic [31:0] crd,
                        input int lat, input logic [31:0] md);
    exp_t e;
    bit   al;
    int   n;
    al = (addr % 4 == 0);
    e.is_load = !st; e.rdata = '0; e.fills = 0; e.upds = 0; e.invs = 0;
    if (st) begin
      e.lat = lat + 2; e.upds = int'(al); e.invs = int'(!al);
    end else if (al && hit) begin
      e.lat = 0; e.rdata = ref_ext(crd, w);
    end else begin
      e.lat = lat + 2; e.rdata = ref_ext(md, w); e.fills = int'(al);
      model_mc = sat(model_mc + 1);
    end
    e.hc = model_hc;
    e.mc = model_mc;
    if (!st && al && hit) model_hc = sat(model_hc + 1);
    exp_maddr = addr; exp_mwe = st; exp_mwdata = wd;
    exp_mwidth = (st || !al) ? w : 3'b000;
    cur_lat = lat; cur_mdata = md;
    sbq.push_back(e);
    cpu_we = st;
    cpu_re = st ? 1'($urandom_range(0, 1)) : 1'b1;
    cpu_addr = addr; cpu_width = w; cpu_wdata = wd; cache_hit = hit; cache_rdata = crd;
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (stall && n < 100);
    if (stall) begin
      failures++;
      $display("FAIL req_timeout actual=stalled required=done_within_100");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "request timeout");
    end
    @(posedge clk); #1;
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    logic [2:0]  ldw[5];
    logic [31:0] a;
    logic [2:0]  w;
    bit          st;
    int          seen;
    ldw = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110};

    rst = 1'b1; cpu_re = 1'b1; cpu_we = 1'b0; cache_hit = 1'b1;
    cpu_addr = 32'h100; cpu_width = 3'b000; cpu_wdata = '0; cache_rdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_strobes", 32'({fill_en, upd_en, inv_en, mem_we}), 32'd0);
    chk("rst_counts", 32'({hit_count, miss_count}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_re = 1'b0;

    // Reset while a load miss waits in RD.
    exp_maddr = 32'h200; exp_mwe = 1'b0; exp_mwidth = 3'b000; cur_lat = 1000;
    cpu_re = 1'b1; cpu_addr = 32'h200; cache_hit = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk); #2;
      seen += int'(fill_en);
    end
    chk("rd_mem_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; cpu_re = 1'b0;
    @(negedge clk); #2;
    seen += int'(fill_en);
    @(posedge clk); #1;
    chk("rst_rd_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rd_fill", 32'(seen), 32'd0);
    chk("rst_rd_counts", 32'({hit_count, miss_count}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_req(1'b0, 32'h100, 3'b000, '0, 1'b1, 32'hDEAD_BEEF, 0, '0);
    do_req(1'b0, 32'h104, 3'b010, '0, 1'b0, 32'h1111_1111, 3, 32'h0000_0080);
    chk("lb_miss_value", ref_ext(32'h0000_0080, 3'b010), 32'hFFFF_FF80);
    do_req(1'b1, 32'h108, 3'b000, 32'h1234_5678, 1'b1, '0, 2, '0);
    do_req(1'b1, 32'h10A, 3'b001, 32'h0000_ABCD, 1'b1, '0, 1, '0);
    do_req(1'b0, 32'h10B, 3'b110, '0, 1'b1, 32'h5555_5555, 0, 32'h0000_00F0);
    repeat (20) do_req(1'b0, 32'h300, 3'b001, '0, 1'b1, 32'h0000_8001, 0, '0);
    chk("hit_sat", 32'(hit_count), 32'(SATMAX));

    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 2) == 0);
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a - (a % 4);
      w = st ? 3'($urandom_range(0, 2)) : ldw[$urandom_range(0, 4)];
      do_req(st, a, w, $urandom, 1'($urandom_range(0, 1)), $urandom,
             $urandom_range(0, 3), $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_leftover actual=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
